// File: rtl/act_diff_pipe.sv
// Two-stage activation-derivative / backprop gate: S1 forms f'(x), S2 forms (grad*f'(x))>>>FRAC.
// Latency 2 cycles, 1 beat/cycle; valid/ready backpressure, stages hold while blocked. Optional ACT_DIFF_STAT_EN adds dead_cnt.
module act_diff_pipe #(
    parameter int NBITS      = 16,
    parameter int FRAC       = 8,
    parameter int NCH        = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [NCH*NBITS-1:0] x_in,
    input  logic [NCH*NBITS-1:0] grad_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH*NBITS-1:0] deriv_out,
    output logic [NCH*NBITS-1:0] grad_out
`ifdef ACT_DIFF_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        dead_cnt
`endif
);

    localparam logic [NBITS-1:0] ONE  = NBITS'(1) << FRAC;
    localparam logic [NBITS-1:0] LEAK = ONE >> LEAK_SHIFT;

    logic                   s1_valid;
    logic [NCH*NBITS-1:0]   s1_grad;
    logic [NCH*NBITS-1:0]   s1_deriv;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;
    logic [NCH*NBITS-1:0]   deriv_nxt;
    logic [NCH*NBITS-1:0]   gated_nxt;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Sign bit clear (including zero) passes the gradient at unity slope.
    always_comb begin
        deriv_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!x_in[c*NBITS + NBITS-1])
                deriv_nxt[c*NBITS +: NBITS] = ONE;
            else if (mode)
                deriv_nxt[c*NBITS +: NBITS] = LEAK;
        end
    end

    // |deriv| <= ONE, so the shifted product always fits back in NBITS.
    always_comb begin
        gated_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            logic signed [2*NBITS-1:0] prod;
            prod = $signed(s1_grad[c*NBITS +: NBITS]) * $signed(s1_deriv[c*NBITS +: NBITS]);
            gated_nxt[c*NBITS +: NBITS] = NBITS'(prod >>> FRAC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_grad  <= '0;
            s1_deriv <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_grad  <= grad_in;
                s1_deriv <= deriv_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            deriv_out <= '0;
            grad_out  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                deriv_out <= s1_deriv;
                grad_out  <= gated_nxt;
            end
        end
    end

`ifdef ACT_DIFF_STAT_EN
    logic [15:0] zeros;
    logic [16:0] cnt_sum;

    always_comb begin
        zeros = '0;
        for (int c = 0; c < NCH; c++) begin
            if (deriv_out[c*NBITS +: NBITS] == '0)
                zeros = zeros + 16'd1;
        end
    end

    assign cnt_sum = {1'b0, dead_cnt} + {1'b0, zeros};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dead_cnt <= '0;
        else if (stat_clr)
            dead_cnt <= '0;
        else if (s2_valid && out_ready)
            dead_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_act_diff_pipe.sv
// Self-checking bench for act_diff_pipe: directed vector table, stall/reset sequences, random traffic vs. scoreboard.
module tb_act_diff_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [63:0] x_in = '0;
    logic [63:0] grad_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] deriv_out;
    logic [63:0] grad_out;
`ifdef ACT_DIFF_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] dead_cnt;
`endif

    act_diff_pipe #(.NBITS(16), .FRAC(8), .NCH(4), .LEAK_SHIFT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x_in(x_in), .grad_in(grad_in), .out_valid(out_valid),
        .out_ready(out_ready), .deriv_out(deriv_out), .grad_out(grad_out)
`ifdef ACT_DIFF_STAT_EN
        , .stat_clr(stat_clr), .dead_cnt(dead_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_out = 0;

    typedef struct {
        logic [63:0] d;
        logic [63:0] g;
    } beat_t;
    beat_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: derivative from sign and mode, then plain integer multiply and floor-shift.
    function automatic beat_t model(input logic [63:0] x, input logic [63:0] g, input logic m);
        beat_t b;
        for (int c = 0; c < 4; c++) begin
            int xv, gv, dv, p;
            xv = int'($signed(x[c*16 +: 16]));
            gv = int'($signed(g[c*16 +: 16]));
            dv = (xv >= 0) ? 256 : (m ? 32 : 0);
            p  = gv * dv;
            b.d[c*16 +: 16] = 16'(dv);
            b.g[c*16 +: 16] = 16'(p >>> 8);
        end
        return b;
    endfunction

    // Mid-cycle monitor: inputs change just after posedge, so negedge sees the upcoming handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {63'b0, in_ready}, (sb.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("sb_deriv", deriv_out, e.d);
                    chk("sb_grad", grad_out, e.g);
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(x_in, grad_in, mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] g;
        logic        m;
        logic [15:0] d;
        logic [15:0] go;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic saw_nr;
        int   idx;
        logic [63:0] bx[6];
        logic [63:0] bg[6];

        vt[0] = '{16'h0100, 16'h0200, 1'b0, 16'h0100, 16'h0200};
        vt[1] = '{16'hFF00, 16'h0200, 1'b0, 16'h0000, 16'h0000};
        vt[2] = '{16'hFF00, 16'h0200, 1'b1, 16'h0020, 16'h0040};
        vt[3] = '{16'hFF00, 16'hFE00, 1'b1, 16'h0020, 16'hFFC0};
        vt[4] = '{16'h0000, 16'h0200, 1'b0, 16'h0100, 16'h0200};
        vt[5] = '{16'h7FFF, 16'h8000, 1'b0, 16'h0100, 16'h8000};
        vt[6] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0020, 16'h0FFF};
        vt[7] = '{16'h8000, 16'h8001, 1'b1, 16'h0020, 16'hF000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_deriv", deriv_out, 64'd0);
        chk("rst_grad", grad_out, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        step();

        // Directed table with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            mode     = vt[i].m;
            x_in     = {4{vt[i].x}};
            grad_in  = {4{vt[i].g}};
            step();
            in_valid = 1'b0;
            chk("lat_not_yet", {63'b0, out_valid}, 64'd0);
            step();
            chk("lat_valid", {63'b0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_deriv", i), deriv_out, {4{vt[i].d}});
            chk($sformatf("vec%0d_grad", i), grad_out, {4{vt[i].go}});
            step();
        end

        // Six-beat stream with out_ready low during cycles 2-5
        for (int i = 0; i < 6; i++) begin
            bx[i] = {$urandom, $urandom};
            bg[i] = {$urandom, $urandom};
        end
        n_out  = 0;
        idx    = 0;
        saw_nr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            out_ready = !(k >= 2 && k <= 5);
            in_valid  = (idx < 6);
            mode      = idx[0];
            x_in      = (idx < 6) ? bx[idx] : '0;
            grad_in   = (idx < 6) ? bg[idx] : '0;
            #1;
            if (!in_ready) saw_nr = 1'b1;
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        chk("stall_in_ready_fell", {63'b0, saw_nr}, 64'd1);
        chk("stall_all_out", 64'(n_out), 64'd6);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = $urandom_range(0, 1);
            for (int c = 0; c < 4; c++) begin
                x_in[c*16 +: 16]    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                grad_in[c*16 +: 16] = 16'($urandom);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        chk("random_drain", 64'(sb.size()), 64'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x_in     = {$urandom, $urandom};
            grad_in  = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
        sb.delete();
        step();
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_stale_beat", {63'b0, out_valid}, 64'd0);
        end

`ifdef ACT_DIFF_STAT_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("dead_clr0", 64'(dead_cnt), 64'd0);
        mode    = 1'b0;
        x_in    = {16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
        grad_in = {4{16'h0200}};
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("dead_cnt6", 64'(dead_cnt), 64'd6);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("dead_clr", 64'(dead_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
